// File: rtl/interval_pkg.sv
// Shared types and constants for the interval sequencer: FSM state encoding,
// default slot count / duration width, and the end-of-program marker.
package interval_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        NEXT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_TIME_W    = 6;
    localparam int END_MARK      = 0;

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector: pulse is high for the cycle in which level is
// high and was low on the previous clock edge.
module edge_pulse (
    input  logic clk,
    input  logic srst,
    input  logic level,
    output logic pulse
);

    logic level_q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            level_q_reg <= 1'b0;
        end else begin
            level_q_reg <= level;
        end
    end

    assign pulse = level & ~level_q_reg;

endmodule

// File: rtl/interval_sequencer.sv
// Steps countdown_timer through a programmed list of interval durations.
// Optional build macro INTERVAL_LOOP_EN: repeat the program forever and count laps.
module interval_sequencer
    import interval_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int TIME_W    = DEF_TIME_W,
    localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [TIME_W-1:0] prog_data,
    input  logic              timer_done,
    output logic              load,
    output logic              run,
    output logic [TIME_W-1:0] sw_time,
    output logic [IDX_W-1:0]  seg_idx,
    output logic              busy,
    output logic              all_done
`ifdef INTERVAL_LOOP_EN
    ,
    output logic [7:0]        loop_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  seg_idx_reg, seg_idx_next;
    logic [TIME_W-1:0] slot_reg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic              start_p, pause_p;
    logic              seg_last;
`ifdef INTERVAL_LOOP_EN
    logic              wrap_next;
    logic [7:0]        loop_count_reg;
`endif

    edge_pulse u_start_edge (.clk(clk), .srst(reset), .level(start), .pulse(start_p));
    edge_pulse u_pause_edge (.clk(clk), .srst(reset), .level(pause), .pulse(pause_p));

    // A slot holding the end marker terminates the program.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_valid
            assign slot_valid[gi] = (slot_reg[gi] != TIME_W'(END_MARK));
        end
    endgenerate

    assign seg_last = (seg_idx_reg == LAST_IDX) || !slot_valid[seg_idx_reg + 1'b1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            seg_idx_reg <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_reg[i] <= '0;
            end
`ifdef INTERVAL_LOOP_EN
            loop_count_reg <= 8'd0;
`endif
        end else begin
            state_reg   <= state_next;
            seg_idx_reg <= seg_idx_next;
            if (state_reg == IDLE && prog_we && int'(prog_addr) < NUM_SLOTS) begin
                slot_reg[prog_addr] <= prog_data;
            end
`ifdef INTERVAL_LOOP_EN
            if (wrap_next && loop_count_reg != 8'hFF) begin
                loop_count_reg <= loop_count_reg + 8'd1;
            end
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        seg_idx_next = seg_idx_reg;
`ifdef INTERVAL_LOOP_EN
        wrap_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (start_p && slot_valid[0]) begin
                    state_next   = LOAD;
                    seg_idx_next = '0;
                end
            end
            LOAD:  state_next = RUN;
            RUN: begin
                // timer_done takes priority over a simultaneous pause press
                if (timer_done) begin
                    state_next = NEXT;
                end else if (pause_p) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_p) begin
                    state_next = RUN;
                end
            end
            NEXT: begin
                if (!seg_last) begin
                    state_next   = LOAD;
                    seg_idx_next = seg_idx_reg + 1'b1;
                end else begin
`ifdef INTERVAL_LOOP_EN
                    state_next   = LOAD;
                    seg_idx_next = '0;
                    wrap_next    = 1'b1;
`else
                    state_next   = FINISH;
`endif
                end
            end
            FINISH: begin
                if (start_p) begin
                    state_next   = LOAD;
                    seg_idx_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load     = (state_reg == LOAD);
    assign run      = (state_reg == RUN);
    assign busy     = (state_reg == LOAD) || (state_reg == RUN) ||
                      (state_reg == PAUSE) || (state_reg == NEXT);
    assign all_done = (state_reg == FINISH);
    assign seg_idx  = seg_idx_reg;
    assign sw_time  = load ? slot_reg[seg_idx_reg] : '0;
`ifdef INTERVAL_LOOP_EN
    assign loop_count = loop_count_reg;
`endif

endmodule

// File: tb/tb_interval_sequencer.sv
// Randomized self-checking bench for interval_sequencer: a slot-list model
// predicts the load/run/finish sequence and latencies for each program run.
module tb_interval_sequencer;

    localparam int NS = 4;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          prog_we = 1'b0;
    logic [1:0]    prog_addr = '0;
    logic [TW-1:0] prog_data = '0;
    logic          timer_done = 1'b0;
    logic          load, run, busy, all_done;
    logic [TW-1:0] sw_time;
    logic [1:0]    seg_idx;
`ifdef INTERVAL_LOOP_EN
    logic [7:0]    loop_count;
    localparam int LAPS = 2;
`else
    localparam int LAPS = 1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int model_slot [NS];

    interval_sequencer #(.NUM_SLOTS(NS), .TIME_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .timer_done(timer_done), .load(load), .run(run), .sw_time(sw_time),
        .seg_idx(seg_idx), .busy(busy), .all_done(all_done)
`ifdef INTERVAL_LOOP_EN
        , .loop_count(loop_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of segments a run executes: leading nonzero slots.
    function automatic int lead_count();
        int n = 0;
        while (n < NS && model_slot[n] != 0) n++;
        return n;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_load"}, int'(load), 0);
        check_eq({tag, "_run"}, int'(run), 0);
        check_eq({tag, "_sw_time"}, int'(sw_time), 0);
        check_eq({tag, "_seg_idx"}, int'(seg_idx), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_all_done"}, int'(all_done), 0);
    endtask

    task automatic do_reset();
        start = 0; pause = 0; timer_done = 0; prog_we = 0;
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < NS; i++) model_slot[i] = 0;
    endtask

    task automatic program_slots(input int a, input int b, input int c, input int d);
        int vals [NS];
        vals = '{a, b, c, d};
        for (int i = 0; i < NS; i++) begin
            prog_we = 1; prog_addr = 2'(i); prog_data = TW'(vals[i]);
            tick();
            model_slot[i] = vals[i];
        end
        prog_we = 0;
        $display("program {%0d,%0d,%0d,%0d}", a, b, c, d);
    endtask

    // Press start and follow the whole program, emulating the timer's done flag.
    task automatic run_program();
        int n, total, s, idle;
        bit do_pause, coincide;
        n = lead_count();
        total = n * LAPS;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < total; k++) begin
            s = k % n;
            check_eq("load", int'(load), 1);
            check_eq("sw_time", int'(sw_time), model_slot[s]);
            check_eq("seg_idx", int'(seg_idx), s);
            check_eq("load_busy", int'(busy), 1);
            tick();
            check_eq("run", int'(run), 1);
            check_eq("load_off", int'(load), 0);
            do_pause = (k == 0) || ($urandom_range(0, 2) == 0);
            if (do_pause) begin
                pause = 1;
                tick();
                pause = 0;
                check_eq("paused_run", int'(run), 0);
                check_eq("paused_busy", int'(busy), 1);
                for (int j = 0; j < 2; j++) begin
                    timer_done = 1;
                    tick();
                    timer_done = 0;
                    check_eq("pause_ignores_done", int'(run), 0);
                    check_eq("pause_no_load", int'(load), 0);
                end
                pause = 1;
                tick();
                pause = 0;
                check_eq("resumed_run", int'(run), 1);
            end
            idle = $urandom_range(1, 3);
            for (int j = 0; j < idle; j++) begin
                tick();
                check_eq("run_hold", int'(run), 1);
            end
            coincide = (k == 1) || ($urandom_range(0, 3) == 0);
            timer_done = 1;
            pause = coincide;
            tick();
            timer_done = 0;
            pause = 0;
            check_eq("next_run", int'(run), 0);
            check_eq("next_busy", int'(busy), 1);
            tick();
            $display("segment %0d: sw_time %0d done (pause=%0d coincide=%0d)",
                     k, model_slot[s], do_pause, coincide);
`ifdef INTERVAL_LOOP_EN
            if (s == n - 1) check_eq("loop_count", int'(loop_count), (k + 1) / n);
            if (k == total - 1) check_eq("wrap_load", int'(load), 1);
`else
            if (k == total - 1) begin
                check_eq("finish_all_done", int'(all_done), 1);
                check_eq("finish_seg_idx", int'(seg_idx), n - 1);
                check_eq("finish_busy", int'(busy), 0);
                check_eq("finish_load", int'(load), 0);
            end
`endif
        end
    endtask

    task automatic start_expect_idle(input string tag);
        start = 1;
        tick();
        start = 0;
        check_eq({tag, "_load"}, int'(load), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        tick();
    endtask

    initial begin
        int v [NS];
        do_reset();
        check_idle_outputs("reset");
        start_expect_idle("empty_start");

        program_slots(5, 3, 0, 0);
        run_program();
`ifndef INTERVAL_LOOP_EN
        // Writes in FINISH are dropped; a rerun still sees the old program.
        prog_we = 1; prog_addr = 2'd0; prog_data = '0;
        tick();
        prog_we = 0;
        run_program();
`endif

        do_reset();
        program_slots($urandom_range(1, 63), $urandom_range(1, 63),
                      $urandom_range(1, 63), $urandom_range(1, 63));
        run_program();

`ifdef INTERVAL_LOOP_EN
        do_reset();
        program_slots(2, 2, 0, 0);
        run_program();
`endif

        // Reset in the middle of RUN drops the program.
        do_reset();
        program_slots(7, 9, 0, 0);
        start = 1;
        tick();
        start = 0;
        tick();
        check_eq("pre_reset_run", int'(run), 1);
        do_reset();
        check_idle_outputs("mid_reset");
        start_expect_idle("after_reset_start");

        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < NS; i++)
                v[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 63);
            program_slots(v[0], v[1], v[2], v[3]);
            if (lead_count() == 0) start_expect_idle("rand_empty");
            else run_program();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
